mix_columns_seq: RTL and testbench

Sequenced MixColumns engine for the AES round datapath. It accepts a 128-bit state, pushes COLS_PER_CYCLE columns per clock through an internal bank of four single-column byte multipliers (rows 0..3), and assembles the 128-bit result. It presents the result on a valid/ready handshake. It sits between ShiftRows and AddRoundKey and lets the round controller trade area against latency.

---
 rtl/mix_columns_seq.sv | 139 +++++++++++++
 tb/tb_mix_columns_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Sequenced AES MixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Define MIXCOL_INV_EN to add the inv port and the InvMixColumns path.

module mix_col (
  input  logic [31:0] col,
`ifdef MIXCOL_INV_EN
  input  logic        inv,
`endif
  output logic [31:0] res
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a [4];
  logic [7:0] x2 [4];
  logic [7:0] b [4];
`ifdef MIXCOL_INV_EN
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
`endif

  always_comb begin
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xt(a[r]);
`ifdef MIXCOL_INV_EN
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
`endif
    end
    for (int r = 0; r < 4; r++) begin
      // row r sees the row-0 coefficients rotated right by r
      b[r] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
`ifdef MIXCOL_INV_EN
      if (inv)
        b[r] = (x8[r] ^ x4[r] ^ x2[r])
             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
             ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
`endif
      res[31-8*r -: 8] = b[r];
    end
  end
endmodule

module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
`ifdef MIXCOL_INV_EN
  ,input  logic        inv
`endif
);
  localparam int C = COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(4 - C);
  localparam logic [1:0] STEP = 2'(C);  // 4 wraps to 0: one pass covers all columns

  if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cfg
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [3:0][31:0]   src;    // [3] holds column 0
  logic [3:0][31:0]   out_q;
  logic [1:0]         col_cnt;
  logic [C-1:0][1:0]  col_idx;
  logic [C-1:0][31:0] col_res;
`ifdef MIXCOL_INV_EN
  logic               inv_q;
`endif

  for (genvar k = 0; k < C; k++) begin : g_col
    assign col_idx[k] = col_cnt + 2'(k);
    mix_col u_col (
      .col (src[2'd3 - col_idx[k]]),
`ifdef MIXCOL_INV_EN
      .inv (inv_q),
`endif
      .res (col_res[k])
    );
  end

  assign state_out = out_q;
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (col_cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src       <= '0;
      out_q     <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          src     <= state_in;
          col_cnt <= '0;
`ifdef MIXCOL_INV_EN
          inv_q   <= inv;
`endif
        end
        RUN: begin
          for (int k = 0; k < C; k++) out_q[2'd3 - col_idx[k]] <= col_res[k];
          col_cnt <= col_cnt + STEP;
          if (col_cnt == LAST) out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances (1, 2, 4 columns/cycle) driven side by side.
// Exercises the inverse path as well when MIXCOL_INV_EN is defined.

module tb_mix_columns_seq;
  localparam logic [127:0] A_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] A_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] B_IN  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam logic [127:0] B_OUT = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ordy = 1'b0;
  logic [2:0]   iv = '0;
  logic [127:0] si [3];
  wire  [2:0]   rdy, ov, bsy;
  wire  [127:0] so [3];
`ifdef MIXCOL_INV_EN
  logic         inv = 1'b0;
`endif

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .state_in(si[0]),
    .out_valid(ov[0]), .out_ready(ordy), .state_out(so[0]), .busy(bsy[0])
`ifdef MIXCOL_INV_EN
    , .inv(inv)
`endif
  );
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .state_in(si[1]),
    .out_valid(ov[1]), .out_ready(ordy), .state_out(so[1]), .busy(bsy[1])
`ifdef MIXCOL_INV_EN
    , .inv(inv)
`endif
  );
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .state_in(si[2]),
    .out_valid(ov[2]), .out_ready(ordy), .state_out(so[2]), .busy(bsy[2])
`ifdef MIXCOL_INV_EN
    , .inv(inv)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept one state on all instances, check latency, hold 10 cycles, then release
  task automatic run_one(input logic [127:0] din, input logic [127:0] dexp, input logic [127:0] other);
    logic [2:0] exp_ov;
    for (int i = 0; i < 3; i++) si[i] = din;
    iv = 3'b111;
    tick();
    iv = '0;
    chk("busy_run", 128'(bsy), 128'(3'b111));
    chk("rdy_run", 128'(rdy), 128'(3'b000));
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      for (int i = 0; i < 3; i++) exp_ov[i] = (cyc >= (4 >> i));
      chk($sformatf("lat_ov_cyc%0d", cyc), 128'(ov), 128'(exp_ov));
    end
    for (int i = 0; i < 3; i++) si[i] = other;
    iv = 3'b111;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("hold_ov", 128'(ov), 128'(3'b111));
      chk("hold_rdy", 128'(rdy), 128'(3'b000));
      for (int i = 0; i < 3; i++) chk($sformatf("hold_out_u%0d", i), so[i], dexp);
    end
    iv = '0;
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("rel_ov", 128'(ov), 128'(3'b000));
    chk("rel_rdy", 128'(rdy), 128'(3'b111));
    chk("rel_busy", 128'(bsy), 128'(3'b000));
  endtask

  initial begin
    int acc_n [3];
    int res_n [3];
    int acc_cyc [3][2];
    logic [2:0] acc, xf;

    for (int i = 0; i < 3; i++) si[i] = '0;
    tick();
    chk("rst_rdy", 128'(rdy), 128'(3'b000));
    chk("rst_ov", 128'(ov), 128'(3'b000));
    chk("rst_busy", 128'(bsy), 128'(3'b000));
    for (int i = 0; i < 3; i++) chk($sformatf("rst_out_u%0d", i), so[i], '0);
    rst = 1'b0;
    #1;
    chk("idle_rdy", 128'(rdy), 128'(3'b111));

    run_one(A_IN, A_OUT, B_IN);
    run_one(B_IN, B_OUT, A_IN);

    // reset after two columns of the 1-column instance
    for (int i = 0; i < 3; i++) si[i] = A_IN;
    iv = 3'b111;
    tick();
    iv = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_ov", 128'(ov), 128'(3'b000));
    chk("abort_busy", 128'(bsy), 128'(3'b000));
    for (int i = 0; i < 3; i++) chk($sformatf("abort_out_u%0d", i), so[i], '0);
    rst = 1'b0;
    #1;
    chk("abort_rdy", 128'(rdy), 128'(3'b111));
    run_one(B_IN, B_OUT, A_IN);

    // back-to-back: in_valid held, out_ready high
    for (int i = 0; i < 3; i++) begin
      acc_n[i] = 0;
      res_n[i] = 0;
      acc_cyc[i][0] = 0;
      acc_cyc[i][1] = 0;
    end
    ordy = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        iv[i] = (acc_n[i] < 2);
        si[i] = (acc_n[i] == 0) ? A_IN : B_IN;
      end
      for (int i = 0; i < 3; i++) begin
        acc[i] = iv[i] & rdy[i];
        xf[i]  = ov[i] & ordy;
        if (xf[i]) begin
          chk($sformatf("b2b_out_u%0d_r%0d", i, res_n[i]), so[i], (res_n[i] == 0) ? A_OUT : B_OUT);
          res_n[i]++;
        end
      end
      tick();
      for (int i = 0; i < 3; i++)
        if (acc[i]) begin
          if (acc_n[i] < 2) acc_cyc[i][acc_n[i]] = cyc;
          acc_n[i]++;
        end
    end
    ordy = 1'b0;
    iv = '0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_acc_u%0d", i), 128'(acc_n[i]), 128'(2));
      chk($sformatf("b2b_res_u%0d", i), 128'(res_n[i]), 128'(2));
      chk($sformatf("b2b_gap_u%0d", i), 128'(acc_cyc[i][1] - acc_cyc[i][0]), 128'((4 >> i) + 2));
    end

`ifdef MIXCOL_INV_EN
    inv = 1'b1;
    for (int i = 0; i < 3; i++) si[i] = A_OUT;
    iv = 3'b111;
    tick();
    iv = '0;
    inv = 1'b0;
    repeat (4) tick();
    chk("inv_ov", 128'(ov), 128'(3'b111));
    for (int i = 0; i < 3; i++) chk($sformatf("inv_out_u%0d", i), so[i], A_IN);
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
